// File: rtl/dmem_responder.sv
// Word-organised data RAM responder for the mem_in/mem_out request interface.
// Each request is accessed at acceptance, then answered with a single mem_ready pulse after WAIT_STATES cycles.
module dmem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          accept;
  logic          fault;
  logic          wr_en;

  // Modulo-2^32 subtraction makes addresses below BASE_ADDR land out of range.
  always_comb begin
    offset   = mem_addr - BASE_ADDR;
    in_range = ({1'b0, offset} < DEPTH_BYTES);
    idx      = offset[AW+1:2];
    accept   = (state_q == S_IDLE) && mem_valid && !rst;
    fault    = !in_range || (mem_instr && (mem_wstrb != '0));
    wr_en    = accept && !fault && (mem_wstrb != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d   = fault;
          rdata_d = (fault || (mem_wstrb != '0)) ? '0 : mem[idx];
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            ready_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = S_RESP;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (mem_wstrb[k]) mem[idx][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign mem_error = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word-array reference model predicts each response,
// and a negedge monitor checks data, error flag and arrival cycle.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int unsigned WS    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;

  dmem_responder #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: range by modular offset, instruction-fetch writes fault, strobed byte update.
  function automatic void model(input logic instr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                output logic [31:0] rd, output logic er);
    logic [31:0] off;
    int unsigned w;
    off = addr - BASE;
    if (off >= DEPTH * 4 || (instr && wstrb != 4'h0)) begin
      rd = 32'h0;
      er = 1'b1;
    end else begin
      er = 1'b0;
      w  = off / 4;
      if (wstrb == 4'h0) begin
        rd = ref_mem[w];
      end else begin
        for (int k = 0; k < 4; k++)
          if (wstrb[k]) ref_mem[w][8*k +: 8] = wdata[8*k +: 8];
        rd = 32'h0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en && mem_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", mem_rdata, e.rdata);
        check("error", {31'h0, mem_error}, {31'h0, e.err});
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; holds valid through RESP and drops it one cycle later.
  task automatic do_req(input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_t e;
    bit   seen;
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    model(instr, addr, wdata, wstrb, e.rdata, e.err);
    e.cyc = cyc + 1 + WS;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got no ready expected ready at cycle %0d", e.cyc);
      void'(sb.pop_front());
    end
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    logic        ins;
    logic [31:0] dummy_rd;
    logic        dummy_er;

    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, mem_ready}, 32'h0);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_error", {31'h0, mem_error}, 32'h0);

    // Simultaneous reset and request: must not be accepted.
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h10;
    mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'hF;
    @(negedge clk);
    rst       = 1'b0;
    mem_valid = 1'b0;
    mon_en    = 1'b1;
    check("rst_valid_no_ready", {31'h0, mem_ready}, 32'h0);

    for (int unsigned w = 0; w < DEPTH; w++)
      do_req(1'b0, BASE + 4 * w, $urandom, 4'hF);

    do_req(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    do_req(1'b0, BASE + 32'h20, 32'h1122_3344, 4'hF);
    do_req(1'b0, BASE + 32'h20, 32'hAAAA_AAAA, 4'b0101);
    do_req(1'b0, BASE + 32'h20, 32'h0, 4'h0);
    check("strobe_model", ref_mem[8], 32'h11AA_33AA);
    do_req(1'b0, BASE + 32'h22, 32'h0, 4'h0);

    do_req(1'b0, BASE + DEPTH * 4, 32'h0, 4'h0);
    do_req(1'b0, BASE + DEPTH * 4, 32'h9999_9999, 4'hF);
    do_req(1'b0, BASE - 4, 32'h7777_7777, 4'hF);
    do_req(1'b0, 32'h0, 32'h0, 4'h0);
    do_req(1'b0, BASE, 32'h0, 4'h0);
    do_req(1'b0, BASE + DEPTH * 4 - 4, 32'h0, 4'h0);

    do_req(1'b1, BASE, 32'h0000_00EE, 4'h1);
    do_req(1'b1, BASE, 32'h0, 4'h0);
    do_req(1'b0, BASE, 32'h0, 4'h0);

    // Reset while in WAIT: write sticks, no response ever appears.
    mem_valid = 1'b1;
    mem_instr = 1'b0;
    mem_addr  = BASE + 32'h8;
    mem_wdata = 32'h5A5A_5A5A;
    mem_wstrb = 4'hF;
    model(1'b0, BASE + 32'h8, 32'h5A5A_5A5A, 4'hF, dummy_rd, dummy_er);
    @(negedge clk);
    check("rstwait_ready_t1", {31'h0, mem_ready}, 32'h0);
    rst       = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("rstwait_ready_t2", {31'h0, mem_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_ready_t3", {31'h0, mem_ready}, 32'h0);
    @(negedge clk);
    check("rstwait_ready_t4", {31'h0, mem_ready}, 32'h0);
    do_req(1'b0, BASE + 32'h8, 32'h0, 4'h0);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) a = BASE + $urandom_range(0, DEPTH * 4 - 1);
      else if ($urandom_range(0, 1) == 0) a = BASE + DEPTH * 4 + $urandom_range(0, 64);
      else a = $urandom;
      s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ins = ($urandom_range(0, 4) == 0);
      do_req(ins, a, $urandom, s);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
